// File: rtl/thresholding_out_packer.sv
// Packs byte-aligned thresholded elements PACK-per-word into a wide AXI stream.
// A pixel (C channels) always closes its word: unused lanes are zeroed and TLAST is set.
module thresholding_out_packer_lane #(
    parameter int O_BITS = 4,
    parameter int LW     = 2,
    parameter int IDX    = 0
) (
    input  logic [LW-1:0]     lane_sel,
    input  logic [O_BITS-1:0] acc_lane,
    input  logic [O_BITS-1:0] din,
    output logic [O_BITS-1:0] acc_wr,
    output logic [O_BITS-1:0] word_lane
);
    logic hit;
    logic below;

    assign hit   = (lane_sel == LW'(IDX));
    assign below = (lane_sel > LW'(IDX));

    always_comb begin
        acc_wr    = hit ? din : acc_lane;
        word_lane = '0;
        if (hit)        word_lane = din;
        else if (below) word_lane = acc_lane;
    end
endmodule

module thresholding_out_packer #(
    parameter int O_BITS = 4,
    parameter int C      = 8,
    parameter int PACK   = 4,
    localparam int IW    = ((O_BITS + 7) / 8) * 8,
    localparam int OW    = ((PACK * O_BITS + 7) / 8) * 8
) (
    input  logic          ap_clk,
    input  logic          ap_rst,
    output logic          s_axis_tready,
    input  logic          s_axis_tvalid,
    input  logic [IW-1:0] s_axis_tdata,
    input  logic          m_axis_tready,
    output logic          m_axis_tvalid,
    output logic [OW-1:0] m_axis_tdata,
    output logic          m_axis_tlast
);
    localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    localparam logic [LW-1:0] L_MAX = LW'(PACK - 1);
    localparam logic [KW-1:0] K_MAX = KW'(C - 1);

    logic [LW-1:0] l_q, l_d;
    logic [KW-1:0] k_q, k_d;
    logic [PACK-1:0][O_BITS-1:0] acc_q, acc_d, acc_wr, word;
    logic [PACK-1:0][O_BITS-1:0] odata_q, odata_d;
    logic ovld_q, ovld_d, olast_q, olast_d;
    logic completing, pix_end, accept;
    logic [O_BITS-1:0] din;
    logic unused_bits;

    assign din         = s_axis_tdata[O_BITS-1:0];
    assign unused_bits = ^s_axis_tdata;

    // Lane j takes the new element when selected, keeps lower lanes, zeroes upper lanes.
    for (genvar j = 0; j < PACK; j++) begin : g_lane
        thresholding_out_packer_lane #(
            .O_BITS(O_BITS),
            .LW    (LW),
            .IDX   (j)
        ) u_lane (
            .lane_sel (l_q),
            .acc_lane (acc_q[j]),
            .din      (din),
            .acc_wr   (acc_wr[j]),
            .word_lane(word[j])
        );
    end

    // Ready depends only on registered state and downstream ready, never on s_axis_tvalid.
    assign pix_end       = (k_q == K_MAX);
    assign completing    = (l_q == L_MAX) || pix_end;
    assign s_axis_tready = !completing || !ovld_q || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        l_d     = l_q;
        k_d     = k_q;
        acc_d   = acc_q;
        odata_d = odata_q;
        ovld_d  = ovld_q;
        olast_d = olast_q;
        if (m_axis_tready && ovld_q) ovld_d = 1'b0;
        if (accept) begin
            if (completing) begin
                odata_d = word;
                olast_d = pix_end;
                ovld_d  = 1'b1;
                acc_d   = '0;
                l_d     = '0;
                k_d     = pix_end ? '0 : k_q + KW'(1);
            end else begin
                acc_d = acc_wr;
                l_d   = l_q + LW'(1);
                k_d   = k_q + KW'(1);
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            l_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            odata_q <= '0;
            ovld_q  <= 1'b0;
            olast_q <= 1'b0;
        end else begin
            l_q     <= l_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            odata_q <= odata_d;
            ovld_q  <= ovld_d;
            olast_q <= olast_d;
        end
    end

    assign m_axis_tvalid = ovld_q;
    assign m_axis_tdata  = OW'(odata_q);
    assign m_axis_tlast  = olast_q;
endmodule

// File: tb/tb_thresholding_out_packer.sv
// Directed and randomized-handshake bench for thresholding_out_packer in three configurations.
module tb_thresholding_out_packer;
    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    always #5 ap_clk = ~ap_clk;

    // main DUT: O_BITS=4, C=8, PACK=4
    logic        s_tvalid, s_tready, m_tready, m_tvalid, m_tlast;
    logic [7:0]  s_tdata;
    logic [15:0] m_tdata;
    // C=6 DUT and C=4 DUT, downstream always ready
    logic        s6_tvalid, s6_tready, m6_tvalid, m6_tlast;
    logic [7:0]  s6_tdata;
    logic [15:0] m6_tdata;
    logic        s4_tvalid, s4_tready, m4_tvalid, m4_tlast;
    logic [7:0]  s4_tdata;
    logic [15:0] m4_tdata;

    thresholding_out_packer #(.O_BITS(4), .C(8), .PACK(4)) u_dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_tready(s_tready), .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .m_axis_tready(m_tready), .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast));

    thresholding_out_packer #(.O_BITS(4), .C(6), .PACK(4)) u_dut6 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_tready(s6_tready), .s_axis_tvalid(s6_tvalid), .s_axis_tdata(s6_tdata),
        .m_axis_tready(1'b1), .m_axis_tvalid(m6_tvalid), .m_axis_tdata(m6_tdata),
        .m_axis_tlast(m6_tlast));

    thresholding_out_packer #(.O_BITS(4), .C(4), .PACK(4)) u_dut4 (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .s_axis_tready(s4_tready), .s_axis_tvalid(s4_tvalid), .s_axis_tdata(s4_tdata),
        .m_axis_tready(1'b1), .m_axis_tvalid(m4_tvalid), .m_axis_tdata(m4_tdata),
        .m_axis_tlast(m4_tlast));

    int n_cmp = 0;
    int n_bad = 0;
    int n_last = 0;
    logic rnd_on = 1'b0;
    logic [16:0] q6[$];
    logic [16:0] q4[$];
    logic [16:0] exp_q[$];
    logic [3:0]  elems[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    always @(negedge ap_clk) begin
        if (m6_tvalid) q6.push_back({m6_tlast, m6_tdata});
        if (m4_tvalid) q4.push_back({m4_tlast, m4_tdata});
        if (rnd_on && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) chk("rnd_extra", {m_tlast, m_tdata}, 32'hDEAD);
            else                   chk("rnd_word", {m_tlast, m_tdata}, exp_q.pop_front());
            if (m_tlast) n_last++;
        end
    end

    // 0x1..0x8 with downstream always ready
    task automatic run_basic(input string tag);
        m_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(i);
            @(negedge ap_clk);
            chk({tag, "_srdy"}, s_tready, 1);
            if (i == 5) chk({tag, "_w1"}, {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 16'h4321});
            if (i == 6) chk({tag, "_w1_gone"}, m_tvalid, 0);
            step();
        end
        s_tvalid = 1'b0;
        @(negedge ap_clk);
        chk({tag, "_w2"}, {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 16'h8765});
        step();
        @(negedge ap_clk);
        chk({tag, "_idle"}, m_tvalid, 0);
        step();
    endtask

    initial begin
        logic acc;
        int   e;
        int   idx;
        int   budget;
        logic [15:0] w;
        logic [16:0] exp6 [4];

        s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
        s6_tvalid = 1'b0; s6_tdata = '0;
        s4_tvalid = 1'b0; s4_tdata = '0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_srdy", s_tready, 1);
        step();
        ap_rst = 1'b0;

        run_basic("a");

        // downstream stall: 5,6,7 accepted, 8 held off until release
        m_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(i);
            step();
        end
        m_tready = 1'b0;
        e = 5;
        for (int c = 0; c < 6; c++) begin
            s_tdata = 8'(e);
            @(negedge ap_clk);
            chk("c_srdy", s_tready, (c < 3) ? 1 : 0);
            chk("c_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b0, 16'h4321});
            acc = s_tvalid && s_tready;
            step();
            if (acc) e++;
        end
        chk("c_elem", e, 8);
        m_tready = 1'b1;
        s_tdata  = 8'(e);
        @(negedge ap_clk);
        chk("c_rel_srdy", s_tready, 1);
        chk("c_rel_w1", {m_tvalid, m_tdata}, {1'b1, 16'h4321});
        step();
        s_tvalid = 1'b0;
        @(negedge ap_clk);
        chk("c_w2", {m_tvalid, m_tlast, m_tdata}, {1'b1, 1'b1, 16'h8765});
        step();
        @(negedge ap_clk);
        chk("c_idle", m_tvalid, 0);
        step();

        // asynchronous reset after two elements of a pixel
        for (int i = 1; i <= 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(i);
            step();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        @(negedge ap_clk);
        chk("e_pre_tdata", m_tdata, 16'h8765);
        ap_rst = 1'b1;
        #1;
        chk("e_rst_tdata", m_tdata, 0);
        chk("e_rst_tvalid", m_tvalid, 0);
        chk("e_rst_tlast", m_tlast, 0);
        step();
        ap_rst = 1'b0;
        run_basic("e");

        // random valid/ready over 50 pixels against a stream-level packing model
        for (int p = 0; p < 50; p++) begin
            for (int hw = 0; hw < 2; hw++) begin
                w = '0;
                for (int j = 0; j < 4; j++) begin
                    elems.push_back(4'($urandom_range(0, 15)));
                    w[j*4 +: 4] = elems[elems.size() - 1];
                end
                exp_q.push_back({(hw == 1) ? 1'b1 : 1'b0, w});
            end
        end
        rnd_on = 1'b1;
        idx = 0;
        budget = 0;
        while (idx < 400 && budget < 5000) begin
            if (!s_tvalid && $urandom_range(0, 2) != 0) begin
                s_tvalid = 1'b1;
                s_tdata  = {4'($urandom_range(0, 15)), elems[idx]};
            end
            m_tready = ($urandom_range(0, 3) != 0);
            @(negedge ap_clk);
            acc = s_tvalid && s_tready;
            step();
            budget++;
            if (acc) begin
                idx++;
                s_tvalid = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (4) step();
        rnd_on = 1'b0;
        chk("rnd_sent", idx, 400);
        chk("rnd_left", exp_q.size(), 0);
        chk("rnd_tlast", n_last, 50);

        // C=6: short tail word per pixel, next pixel restarts at lane 0
        for (int i = 1; i <= 12; i++) begin
            s6_tvalid = 1'b1;
            s6_tdata  = 8'(i);
            step();
        end
        s6_tvalid = 1'b0;
        repeat (3) step();
        exp6[0] = {1'b0, 16'h4321};
        exp6[1] = {1'b1, 16'h0065};
        exp6[2] = {1'b0, 16'hA987};
        exp6[3] = {1'b1, 16'h00CB};
        chk("b_count", q6.size(), 4);
        for (int j = 0; j < 4; j++)
            chk("b_word", (j < q6.size()) ? q6[j] : 17'h1FFFF, exp6[j]);

        // C=4: upper input bits ignored
        for (int i = 0; i < 4; i++) begin
            s4_tvalid = 1'b1;
            s4_tdata  = 8'hF3 - 8'(i * 17);
            step();
        end
        s4_tvalid = 1'b0;
        repeat (3) step();
        chk("f_count", q4.size(), 1);
        chk("f_word", (q4.size() > 0) ? q4[0] : 17'h1FFFF, {1'b1, 16'h0123});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
